// File: rtl/bufg_ce.sv
// Glitch-free clock gate: a low-transparent enable latch ANDed with the clock,
// with an optional chain of falling-edge flops in front of the latch.
module bufg_ce #(
    parameter int SYNC_STAGES    = 0,
    parameter bit IS_CE_INVERTED = 1'b0,
    parameter bit IS_I_INVERTED  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    output logic o,
    output logic gate_en
);

    logic ci;
    logic cei;
    logic en_d;
    logic en_q = 1'b0;

    assign ci  = clk ^ IS_I_INVERTED;
    assign cei = ce ^ IS_CE_INVERTED;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign en_d = cei;
        end else begin : g_sync
            // Falling-edge stages keep every enable change inside the low phase of ci.
            logic [SYNC_STAGES-1:0] sync_q = '0;

            always_ff @(negedge ci or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= cei;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign en_d = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Latch closes on the rising edge of ci, so the enable is frozen for the whole
    // high phase and a same-edge flop update of ce is only seen on the next edge.
    always_latch begin
        if (rst) begin
            en_q <= 1'b0;
        end else if (!ci) begin
            en_q <= en_d;
        end
    end

    assign gate_en = en_q;
    assign o       = ci & en_q;

endmodule

// File: tb/tb_bufg_ce.sv
// Randomized check of bufg_ce variants against a per-edge enable-decision model.
module tb_bufg_ce;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce_a = 1'b0;
    logic ce_ff = 1'b0;
    logic e0 = 1'b0;
    logic e1 = 1'b0;

    logic o0, ge0, o1, ge1, o2, ge2, o3, ge3, o4, ge4;
    logic o5a, ge5a, o5b, ge5b, o6, ge6;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: decisions taken at each edge and falling-edge history of ce.
    logic dec0 = 1'b0, dec1 = 1'b0, dec2 = 1'b0, dec3 = 1'b0;
    logic dec4 = 1'b0, dec5 = 1'b0, dec6 = 1'b0;
    logic h1 = 1'b0, h2 = 1'b0;

    always #10 clk = ~clk;

    always @(posedge clk) ce_ff <= 1'($urandom_range(0, 1));

    bufg_ce #(.SYNC_STAGES(0)) u0 (.clk(clk), .rst(rst), .ce(ce_a), .o(o0), .gate_en(ge0));
    bufg_ce #(.SYNC_STAGES(1)) u1 (.clk(clk), .rst(rst), .ce(ce_a), .o(o1), .gate_en(ge1));
    bufg_ce #(.SYNC_STAGES(2)) u2 (.clk(clk), .rst(rst), .ce(ce_a), .o(o2), .gate_en(ge2));
    bufg_ce #(.SYNC_STAGES(0), .IS_CE_INVERTED(1'b1)) u3 (.clk(clk), .rst(rst), .ce(ce_a), .o(o3), .gate_en(ge3));
    bufg_ce #(.SYNC_STAGES(0)) u4 (.clk(clk), .rst(rst), .ce(ce_ff), .o(o4), .gate_en(ge4));
    bufg_ce #(.SYNC_STAGES(0)) u5a (.clk(clk), .rst(rst), .ce(e0), .o(o5a), .gate_en(ge5a));
    bufg_ce #(.SYNC_STAGES(0)) u5b (.clk(o5a), .rst(rst), .ce(e1), .o(o5b), .gate_en(ge5b));
    bufg_ce #(.SYNC_STAGES(0), .IS_I_INVERTED(1'b1)) u6 (.clk(clk), .rst(rst), .ce(ce_a), .o(o6), .gate_en(ge6));

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // clk high: non-inverted instances show their edge decision, u6 is in its low phase.
    task automatic check_high();
        check_bit("o_sync0", o0, dec0 & ~rst);
        check_bit("ge_sync0", ge0, dec0 & ~rst);
        check_bit("o_sync1", o1, dec1 & ~rst);
        check_bit("ge_sync1", ge1, dec1 & ~rst);
        check_bit("o_sync2", o2, dec2 & ~rst);
        check_bit("ge_sync2", ge2, dec2 & ~rst);
        check_bit("o_ceinv", o3, dec3 & ~rst);
        check_bit("ge_ceinv", ge3, dec3 & ~rst);
        check_bit("o_ffce", o4, dec4 & ~rst);
        check_bit("ge_ffce", ge4, dec4 & ~rst);
        check_bit("o_cascade", o5b, dec5 & ~rst);
        check_bit("o_iinv_low", o6, 1'b0);
    endtask

    task automatic check_low();
        check_bit("o_sync0_low", o0, 1'b0);
        check_bit("o_sync1_low", o1, 1'b0);
        check_bit("o_sync2_low", o2, 1'b0);
        check_bit("o_ceinv_low", o3, 1'b0);
        check_bit("o_ffce_low", o4, 1'b0);
        check_bit("o_cascade_low", o5b, 1'b0);
        check_bit("o_iinv", o6, dec6 & ~rst);
        check_bit("ge_iinv", ge6, dec6 & ~rst);
    endtask

    task automatic set_rst(input logic v);
        if (v) begin
            h1 = 1'b0;
            h2 = 1'b0;
        end
        rst = v;
    endtask

    // One clock period; ce/e changes and reset edges land well away from clock edges.
    task automatic run_cycle(input logic ce_hi, input logic ce_lo, input logic n0,
                             input logic n1, input logic r5, input logic r15);
        @(posedge clk);
        dec0 = ~rst & ce_a;
        dec1 = ~rst & h1;
        dec2 = ~rst & h2;
        dec3 = ~rst & ~ce_a;
        dec4 = ~rst & ce_ff;
        dec5 = ~rst & e0 & e1;
        #1 check_high();
        #2 ce_a = ce_hi;
        #2 set_rst(r5);
        #4 check_high();
        @(negedge clk);
        h2 = ~rst & h1;
        h1 = ~rst & ce_a;
        dec6 = ~rst & ce_a;
        #1 check_low();
        #2 begin
            ce_a = ce_lo;
            e0 = n0;
            e1 = n1;
        end
        #2 set_rst(r15);
        #4 check_low();
    endtask

    initial begin
        logic [1:0] casc_seq [4];
        int sel;
        casc_seq[0] = 2'b01;
        casc_seq[1] = 2'b11;
        casc_seq[2] = 2'b10;
        casc_seq[3] = 2'b00;

        // Initialized state before any reset.
        #1;
        check_bit("init_o0", o0, 1'b0);
        check_bit("init_ge0", ge0, 1'b0);
        check_bit("init_o2", o2, 1'b0);
        check_bit("init_ge2", ge2, 1'b0);
        check_bit("init_o6", o6, 1'b0);
        check_bit("init_ge6", ge6, 1'b0);

        // Reset held with ce high and the clock running.
        #1 begin
            set_rst(1'b1);
            ce_a = 1'b1;
        end
        repeat (5) run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Enable set in the low phase, then cleared in the low phase.
        repeat (4) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Mid-high toggles: 0->1 and 1->0 three units into the high phase.
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Cascade enables 01, 11, 10, 00 held two cycles each.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] p;
            p = casc_seq[i];
            repeat (2) run_cycle(ce_a, ce_a, p[1], p[0], 1'b0, 1'b0);
        end
        repeat (2) run_cycle(ce_a, ce_a, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional short reset pulses.
        for (int c = 0; c < 300; c++) begin
            sel = int'($urandom_range(0, 59));
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      sel == 0, sel == 1);
        end
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
